deck_shuffler: RTL and testbench

Synthesizable 52-card deck source for the blackjack datapath. It fills a card store with 0..51 and permutes it in place with a Fisher–Yates shuffle driven by an internal 6-bit LFSR. It then serves cards one at a time over a request/valid handshake to the dealer/player totalling stage downstream. Each card is output as a raw index and as its blackjack value.

---
 rtl/deck_shuffler.sv | 145 ++++++++++++++
 tb/tb_deck_shuffler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/deck_shuffler.sv
// 52-card deck source: fills a card store, Fisher-Yates shuffles it with a 6-bit LFSR,
// then deals cards one per request with their blackjack value.
module deck_shuffler #(
    parameter int unsigned NUM_CARDS    = 52,
    parameter logic [5:0]  DEFAULT_SEED = 6'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seed,
    input  logic       seed_load,
    input  logic       shuffle_start,
    output logic       busy,
    output logic       deck_ready,
    input  logic       deal_req,
    output logic       deal_valid,
    output logic [5:0] card,
    output logic [3:0] card_value,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    localparam logic [5:0] NumCards = 6'(NUM_CARDS);
    localparam logic [5:0] LastIdx  = 6'(NUM_CARDS - 1);

    typedef enum logic [1:0] {StIdle, StInit, StShuf, StReady} state_e;

    state_e     state_q, state_d;
    logic [5:0] deck_q [NUM_CARDS];
    logic [5:0] idx_q, idx_d;
    logic [5:0] ptr_q, ptr_d;
    logic [5:0] lfsr_q, lfsr_d;
    logic [5:0] card_q, card_d;
    logic [3:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic [5:0] cand;
    logic       accept;

    function automatic logic [3:0] card_val(input logic [5:0] c);
        logic [5:0] rank;
        rank = c % 6'd13;
        return (rank >= 6'd9) ? 4'd10 : (rank[3:0] + 4'd1);
    endfunction

    // Candidate swap partner; values above the current index are rejected.
    assign cand   = lfsr_q - 6'd1;
    assign accept = (cand <= idx_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 6'd0;
            ptr_q   <= NumCards;
            lfsr_q  <= DEFAULT_SEED;
            card_q  <= 6'd0;
            value_q <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            lfsr_q  <= lfsr_d;
            card_q  <= card_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    // Card store has no reset; its contents are rebuilt by INIT before any use.
    always_ff @(posedge clk) begin
        if (reset && !shuffle_start) begin
            if (state_q == StInit) begin
                deck_q[idx_q] <= idx_q;
            end else if (state_q == StShuf && accept) begin
                deck_q[idx_q] <= deck_q[cand];
                deck_q[cand]  <= deck_q[idx_q];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        lfsr_d  = lfsr_q;
        card_d  = card_q;
        value_d = value_q;
        valid_d = 1'b0;

        if (seed_load && !busy) begin
            lfsr_d = (seed == 6'd0) ? 6'd1 : seed;
        end else if (state_q == StShuf) begin
            lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
        end

        unique case (state_q)
            StIdle: ;
            StInit: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == LastIdx) begin
                    state_d = StShuf;
                    idx_d   = LastIdx;
                end
            end
            StShuf: begin
                if (accept) begin
                    if (idx_q == 6'd1) begin
                        state_d = StReady;
                        ptr_d   = 6'd0;
                    end else begin
                        idx_d = idx_q - 6'd1;
                    end
                end
            end
            StReady: begin
                if (deal_req && ptr_q < NumCards) begin
                    valid_d = 1'b1;
                    card_d  = deck_q[ptr_q];
                    value_d = card_val(deck_q[ptr_q]);
                    ptr_d   = ptr_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (shuffle_start) begin
            state_d = StInit;
            idx_d   = 6'd0;
            ptr_d   = NumCards;
            valid_d = 1'b0;
            card_d  = card_q;
            value_d = value_q;
        end
    end

    always_comb begin
        busy       = (state_q == StInit) || (state_q == StShuf);
        deck_ready = (state_q == StReady);
        deal_valid = valid_q;
        card       = card_q;
        card_value = value_q;
        cards_left = NumCards - ptr_q;
        deck_empty = (ptr_q == NumCards);
    end

endmodule

// File: tb/tb_deck_shuffler.sv
// Scoreboard bench for deck_shuffler: a reference shuffle predicts every dealt card,
// a monitor compares each deal_valid pulse against the queued expectation.
module tb_deck_shuffler;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] seed;
    logic       seed_load;
    logic       shuffle_start;
    logic       busy;
    logic       deck_ready;
    logic       deal_req;
    logic       deal_valid;
    logic [5:0] card;
    logic [3:0] card_value;
    logic [5:0] cards_left;
    logic       deck_empty;

    deck_shuffler dut (
        .clk          (clk),
        .reset        (reset),
        .seed         (seed),
        .seed_load    (seed_load),
        .shuffle_start(shuffle_start),
        .busy         (busy),
        .deck_ready   (deck_ready),
        .deal_req     (deal_req),
        .deal_valid   (deal_valid),
        .card         (card),
        .card_value   (card_value),
        .cards_left   (cards_left),
        .deck_empty   (deck_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int card;
        int value;
        int left;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   seen [52];

    // Reference model state
    logic [5:0] ml;
    int         md [52];
    int         mptr = 52;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [5:0] lnext(input logic [5:0] l);
        return {l[4:0], l[5] ^ l[4]};
    endfunction

    function automatic int bj_value(input int c);
        int v;
        v = (c % 13) + 1;
        return (v > 10) ? 10 : v;
    endfunction

    task automatic model_shuffle(output int cycles);
        int i, j, t;
        for (int k = 0; k < 52; k++) md[k] = k;
        cycles = 0;
        i = 51;
        while (i >= 1) begin
            j = int'(ml) - 1;
            ml = lnext(ml);
            cycles++;
            if (j <= i) begin
                t = md[i]; md[i] = md[j]; md[j] = t;
                i--;
            end
        end
    endtask

    always @(negedge clk) begin
        if (deal_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected deal_valid", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("deal latency", cyc, mon_e.due);
                check("card", card, mon_e.card);
                check("card_value", card_value, mon_e.value);
                check("cards_left", cards_left, mon_e.left);
                check("deck_empty", deck_empty, (mon_e.left == 0) ? 1 : 0);
                if (card < 6'd52) seen[card] = 1'b1;
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            void'(q.pop_front());
            check("missing deal_valid", 0, 1);
        end
    end

    task automatic pulse_start(input bit load, input logic [5:0] s);
        @(negedge clk);
        shuffle_start = 1'b1;
        seed_load     = load;
        seed          = s;
        @(negedge clk);
        shuffle_start = 1'b0;
        seed_load     = 1'b0;
        check("busy after start", busy, 1);
        check("deck_ready after start", deck_ready, 0);
        check("cards_left during shuffle", cards_left, 0);
        mptr = 52;
        for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    endtask

    task automatic wait_ready(input int exp_lat);
        int n = 0;
        while (deck_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("ready latency", n, exp_lat);
        check("cards_left at ready", cards_left, 52);
        check("deck_empty at ready", deck_empty, 0);
        mptr = 0;
    endtask

    task automatic run_shuffle(input bit load, input logic [5:0] s);
        int c;
        if (load) ml = (s == 6'd0) ? 6'd1 : s;
        pulse_start(load, s);
        model_shuffle(c);
        wait_ready(52 + c);
    endtask

    task automatic deal_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            deal_req = 1'b1;
            if (mptr < 52) begin
                q.push_back('{md[mptr], bj_value(md[mptr]), 51 - mptr, cyc + 1});
                mptr++;
            end
        end
        @(negedge clk);
        deal_req = 1'b0;
    endtask

    task automatic check_perm();
        int cnt = 0;
        @(negedge clk);
        for (int k = 0; k < 52; k++) if (seen[k]) cnt++;
        check("permutation", cnt, 52);
    endtask

    task automatic full_deal();
        deal_n(53);
        check_perm();
        check("cards_left empty", cards_left, 0);
        check("deck_empty after 52", deck_empty, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " deck_ready"}, deck_ready, 0);
        check({tag, " deal_valid"}, deal_valid, 0);
        check({tag, " cards_left"}, cards_left, 0);
        check({tag, " deck_empty"}, deck_empty, 1);
        check({tag, " card"}, card, 0);
        check({tag, " card_value"}, card_value, 0);
    endtask

    initial begin
        int c;
        logic [5:0] saved;
        reset = 1'b0; seed = 6'd0; seed_load = 1'b0; shuffle_start = 1'b0; deal_req = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        ml    = 6'd20;
        deal_n(2);

        // Seeded full deals, repeatability, seed 21 and seed 0 == seed 1
        run_shuffle(1'b1, 6'd20); full_deal();
        run_shuffle(1'b1, 6'd20); full_deal();
        run_shuffle(1'b1, 6'd21); full_deal();
        run_shuffle(1'b1, 6'd0);  full_deal();

        // Restart mid-SHUF after 10 shuffle cycles, then again after 10 deals
        ml = 6'd20;
        pulse_start(1'b1, 6'd20);
        repeat (60) @(negedge clk);
        repeat (10) ml = lnext(ml);
        pulse_start(1'b0, 6'd0);
        model_shuffle(c);
        wait_ready(52 + c);
        deal_n(10);
        pulse_start(1'b0, 6'd0);
        model_shuffle(c);
        wait_ready(52 + c);
        full_deal();

        // shuffle_start beats a simultaneous deal_req
        run_shuffle(1'b1, 6'd33);
        deal_n(5);
        @(negedge clk);
        shuffle_start = 1'b1;
        deal_req      = 1'b1;
        @(negedge clk);
        shuffle_start = 1'b0;
        deal_req      = 1'b0;
        check("collision busy", busy, 1);
        check("collision deck_ready", deck_ready, 0);
        check("collision cards_left", cards_left, 0);
        mptr = 52;
        for (int k = 0; k < 52; k++) seen[k] = 1'b0;
        model_shuffle(c);
        wait_ready(52 + c);
        full_deal();

        // Reset mid-SHUF returns to reset values and stays idle
        pulse_start(1'b0, 6'd0);
        repeat (60) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("mid-shuffle reset");
        reset = 1'b1;
        ml    = 6'd20;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle after reset", {busy, deck_ready}, 2'b00);
        end
        run_shuffle(1'b0, 6'd0);
        full_deal();

        repeat (3) @(negedge clk);
        check("scoreboard drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
